// File: rtl/spike_encoder.sv
// -----------------------------------------------------------------------------
// spike_encoder
//
// Purpose:
//   On a start pulse, compares every neuron membrane voltage against a firing
//   threshold and captures a fire vector. The vector is then sent as a stream
//   of neuron addresses over a valid/ready handshake, lowest index first, at
//   up to one address per cycle. A one-cycle done pulse marks the end of the
//   timestep.
//
// Optional feature (compile-time macro SPIKE_REFRACTORY_EN):
//   When defined, a last_fire register holds the vector captured at the
//   previous start. Neurons that fired last timestep are masked out of the
//   new capture, so no neuron fires in two consecutive timesteps.
//   When undefined, the capture is the plain threshold compare.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-low reset
//   start        in   single-cycle pulse: capture and encode one timestep
//   cur_voltage  in   packed voltages, neuron i at [i*V_W +: V_W]
//   threshold    in   unsigned firing threshold
//   spike_ready  in   downstream accepts spike_addr this cycle
//   spike_valid  out  spike_addr holds a firing neuron
//   spike_addr   out  index of the firing neuron (0 when not valid)
//   fire_vec     out  fire bits not yet sent
//   spike_cnt    out  spikes sent in the current timestep
//   busy         out  encoder is scanning or finishing
//   done         out  one-cycle pulse: timestep fully sent
// -----------------------------------------------------------------------------
module spike_encoder #(
    parameter int N_NUM = 32,
    parameter int N_SZ  = 5,
    parameter int V_W   = 8,
    parameter int CNT_W = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [N_NUM*V_W-1:0]   cur_voltage,
    input  logic [V_W-1:0]         threshold,
    input  logic                   spike_ready,
    output logic                   spike_valid,
    output logic [N_SZ-1:0]        spike_addr,
    output logic [N_NUM-1:0]       fire_vec,
    output logic [CNT_W-1:0]       spike_cnt,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [N_NUM-1:0]   fire_vec_r;
    logic [CNT_W-1:0]   spike_cnt_r;
    logic               busy_r;
    logic               done_r;

    logic [N_NUM-1:0]   cmp_s;
    logic [N_NUM-1:0]   capture_s;
    logic [N_NUM-1:0]   fire_next_s;
    logic               pending_s;
    logic               capture_en_s;

    // Index of the lowest set bit; later (lower) hits overwrite earlier ones.
    function automatic logic [N_SZ-1:0] lowest_set(input logic [N_NUM-1:0] vec);
        logic [N_SZ-1:0] idx;
        idx = {N_SZ{1'b0}};
        for (int i = N_NUM - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = i[N_SZ-1:0];
            end
        end
        return idx;
    endfunction

    // Unsigned threshold compare for every neuron.
    always_comb begin
        cmp_s = {N_NUM{1'b0}};
        for (int i = 0; i < N_NUM; i++) begin
            cmp_s[i] = (cur_voltage[i*V_W +: V_W] >= threshold);
        end
    end

    assign pending_s    = |fire_vec_r;
    assign capture_en_s = (state_r == ST_IDLE) && start;

    // v & (v - 1) clears exactly the lowest set bit, i.e. the address on offer.
    assign fire_next_s  = fire_vec_r & (fire_vec_r - {{(N_NUM-1){1'b0}}, 1'b1});

`ifdef SPIKE_REFRACTORY_EN
    logic [N_NUM-1:0] last_fire_r;

    assign capture_s = cmp_s & ~last_fire_r;

    // Remember the (masked) vector of the previous timestep.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_fire_r <= {N_NUM{1'b0}};
        end else if (capture_en_s) begin
            last_fire_r <= capture_s;
        end else begin
            last_fire_r <= last_fire_r;
        end
    end
`else
    assign capture_s = cmp_s;
`endif

    // Control FSM: capture, serialise one spike per accepted handshake, finish.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            fire_vec_r  <= {N_NUM{1'b0}};
            spike_cnt_r <= {CNT_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        fire_vec_r  <= capture_s;
                        spike_cnt_r <= {CNT_W{1'b0}};
                        busy_r      <= 1'b1;
                        state_r     <= ST_SCAN;
                    end else begin
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    busy_r <= 1'b1;
                    if (!pending_s) begin
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else if (spike_ready) begin
                        fire_vec_r  <= fire_next_s;
                        spike_cnt_r <= spike_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        done_r      <= 1'b0;
                        state_r     <= ST_SCAN;
                    end else begin
                        done_r  <= 1'b0;
                        state_r <= ST_SCAN;
                    end
                end
                ST_DONE: begin
                    // spike_cnt is left alone so the host can read it after done.
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    fire_vec_r <= {N_NUM{1'b0}};
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake outputs decode the registered state and vector only, so they
    // are stable while spike_ready is low.
    always_comb begin
        if ((state_r == ST_SCAN) && pending_s) begin
            spike_valid = 1'b1;
            spike_addr  = lowest_set(fire_vec_r);
        end else begin
            spike_valid = 1'b0;
            spike_addr  = {N_SZ{1'b0}};
        end
    end

    assign fire_vec  = fire_vec_r;
    assign spike_cnt = spike_cnt_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: doc/spike_encoder.md
Name: spike_encoder

Overview:
Output-side counterpart of the spike decoder. Once per timestep it compares the 32 neuron membrane voltages against a firing threshold and captures a fire vector. It then serialises the vector into a stream of neuron addresses (lowest index first) over a valid/ready handshake, for the next layer or the host. It sits after the syn_unit array and is kicked by the controller at the end of the PDE phase.

Parameters:
N_NUM, 32, number of neurons scanned
N_SZ, 5, address width, log2(N_NUM)
V_W, 8, membrane voltage width
CNT_W, 6, spike counter width, holds 0..N_NUM

Ports:
clk  input  1  system clock, all flops rising-edge
rst  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse: capture and encode one timestep
cur_voltage  input  N_NUM*V_W  packed voltages; neuron i at bits [i*V_W +: V_W]
threshold  input  V_W  firing threshold, unsigned
spike_ready  input  1  downstream accepts spike_addr this cycle
spike_valid  output  1  spike_addr holds a firing neuron
spike_addr  output  N_SZ  index of the firing neuron
fire_vec  output  N_NUM  remaining (not yet sent) fire bits
spike_cnt  output  CNT_W  spikes sent in the current timestep
busy  output  1  encoder is in SCAN or DONE
done  output  1  one-cycle pulse: timestep fully sent

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. spike_valid=0, spike_addr=0, fire_vec=0, spike_cnt=0, busy=0, done=0. Reset mid-scan drops all pending spikes.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - On start=1, load fire_vec[i] = (cur_voltage_i >= threshold) for each i, using an unsigned compare.
  - In the same edge, clear spike_cnt to 0 and go to SCAN.
  - start=0: remain in IDLE.
- SCAN:
  - busy=1.
  - If fire_vec==0, go to DONE.
  - Otherwise spike_valid=1 and spike_addr = lowest set index of fire_vec (combinational priority encode of the registered vector).
  - On spike_valid & spike_ready: clear that bit and increment spike_cnt.
  - Next cycle presents the next lowest index, giving one spike per cycle when ready is held high.
  - While spike_ready=0, spike_valid and spike_addr hold stable.
- DONE: done=1 and busy=1 for exactly one cycle, then go to IDLE. spike_cnt holds its value until the next start.
- Latency:
  - start at edge k gives first spike_valid in cycle k+1.
  - With all ready, an n-spike timestep gives done in cycle k+n+2.
  - An empty vector gives done in cycle k+2.
- start while busy=1 is ignored. Inputs are not re-sampled, and no error is flagged.
- threshold=0: all 32 neurons fire. spike_cnt reaches 32 with no wrap, since CNT_W=6.
- Voltages are sampled only on the start edge. Changes during SCAN have no effect.
- spike_valid never asserts outside SCAN. spike_addr returns to 0 when spike_valid=0.

Optional Feature:
SPIKE_REFRACTORY_EN
- Defined:
  - A last_fire register (N_NUM bits, reset 0) holds the vector captured at the previous start.
  - Capture becomes fire_vec = cmp & ~last_fire, and last_fire is updated to this masked vector at the same edge.
  - A neuron therefore cannot fire in two consecutive timesteps.
- Undefined: no last_fire register and no masking; fire_vec = cmp.

Test Plan:
- Reset, then pulse start with cur_voltage_3=0x40, cur_voltage_17=0x80, all others 0x10, threshold=0x40, ready=1 -> spike_addr 3 then 17 on consecutive cycles, then done; spike_cnt=2.
- All voltages 0x00, threshold=0x01, start -> no spike_valid, done in cycle k+2, spike_cnt=0.
- threshold=0x00, ready=1 -> addresses 0..31 in order, spike_cnt=32, done at k+34.
- Two spikes pending (addr 5, 9) with spike_ready held low for 4 cycles -> spike_addr=5 and spike_valid stable for all 4 cycles; addr 9 follows only after ready rises.
- Second start during SCAN, then rst low mid-scan -> the start is ignored; on reset all outputs go to 0 at once and state returns to IDLE.
- With SPIKE_REFRACTORY_EN, neuron 7 above threshold in two consecutive timesteps -> addr 7 sent in the first timestep only; in the third timestep it fires again.
